// File: rtl/poly_interp_mac_if.sv
// Handshake bundle for the polyphase interpolation MAC:
// window input, coefficient write port and pixel output.
interface poly_interp_mac_if #(
  parameter int DATA_WIDTH = 8,
  parameter int TAPS       = 3,
  parameter int PHASES     = 4,
  parameter int COEF_WIDTH = 10,
  parameter int IDX_WIDTH  = 7
) ();
  logic                                in_valid;
  logic                                in_ready;
  logic [IDX_WIDTH-1:0]                in_index;
  logic [TAPS*DATA_WIDTH-1:0]          in_data;
  logic                                coef_we;
  logic [IDX_WIDTH-1:0]                coef_waddr;
  logic [PHASES*TAPS*COEF_WIDTH-1:0]   coef_wdata;
  logic                                out_valid;
  logic                                out_ready;
  logic [PHASES*DATA_WIDTH-1:0]        out_data;
  logic [PHASES-1:0]                   out_sat;

  modport master (
    output in_valid, in_index, in_data,
    output coef_we, coef_waddr, coef_wdata,
    output out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_index, in_data,
    input  coef_we, coef_waddr, coef_wdata,
    input  out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/poly_interp_mac.sv
// Polyphase interpolation MAC: 3-stage pipeline with a
// runtime-writable coefficient bank and per-phase saturation.
module poly_interp_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int TAPS       = 3,
  parameter int PHASES     = 4,
  parameter int COEF_WIDTH = 10,
  parameter int FRAC_BITS  = 8,
  parameter int IDX_WIDTH  = 7
) (
  input logic              clk,
  input logic              rst_n,
  poly_interp_mac_if.slave bus
);
  localparam int CSW = PHASES*TAPS*COEF_WIDTH;
  localparam int PW  = COEF_WIDTH + DATA_WIDTH + 1;
  localparam int SW  = PW + $clog2(TAPS);
  localparam logic signed [SW-1:0] HALF =
    SW'(64'd1 << (FRAC_BITS-1));
  localparam logic signed [SW-1:0] PIX_MAX =
    SW'((64'd1 << DATA_WIDTH) - 64'd1);

  logic                         en;
  logic                         s0_valid;
  logic [TAPS*DATA_WIDTH-1:0]   s0_data;
  logic [CSW-1:0]               s0_coef;
  logic                         s1_valid;
  logic signed [PW-1:0]         prod_c [PHASES][TAPS];
  logic signed [PW-1:0]         s1_prod [PHASES][TAPS];
  logic signed [SW-1:0]         acc_c [PHASES];
  logic signed [SW-1:0]         res_c [PHASES];
  logic [PHASES*DATA_WIDTH-1:0] pix_c;
  logic [PHASES-1:0]            sat_c;
  logic                         out_valid_q;
  logic [PHASES*DATA_WIDTH-1:0] out_data_q;
  logic [PHASES-1:0]            out_sat_q;

  logic [CSW-1:0] bank [2**IDX_WIDTH];

  assign en            = !out_valid_q | bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

  // Bank writes ignore en; the read register samples old contents
  always_ff @(posedge clk) begin
    if (bus.coef_we)
      bank[bus.coef_waddr] <= bus.coef_wdata;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      s0_coef <= bank[bus.in_index];
      s0_data <= bus.in_data;
      s1_prod <= prod_c;
    end
  end

  always_comb begin
    for (int p = 0; p < PHASES; p++) begin
      for (int t = 0; t < TAPS; t++) begin
        prod_c[p][t] =
          PW'($signed(s0_coef[(p*TAPS+t)*COEF_WIDTH +: COEF_WIDTH]))
          * PW'($signed({1'b0, s0_data[t*DATA_WIDTH +: DATA_WIDTH]}));
      end
    end
  end

  // Round half up, then clamp to the unsigned pixel range
  always_comb begin
    pix_c = '0;
    sat_c = '0;
    for (int p = 0; p < PHASES; p++) begin
      acc_c[p] = HALF;
      for (int t = 0; t < TAPS; t++)
        acc_c[p] = acc_c[p] + SW'(s1_prod[p][t]);
      res_c[p] = acc_c[p] >>> FRAC_BITS;
      unique case (1'b1)
        res_c[p][SW-1]: begin
          sat_c[p] = 1'b1;
        end
        (res_c[p] > PIX_MAX): begin
          pix_c[p*DATA_WIDTH +: DATA_WIDTH] = '1;
          sat_c[p] = 1'b1;
        end
        default: begin
          pix_c[p*DATA_WIDTH +: DATA_WIDTH] =
            res_c[p][DATA_WIDTH-1:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid    <= 1'b0;
      s1_valid    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
    end else if (en) begin
      s0_valid    <= bus.in_valid;
      s1_valid    <= s0_valid;
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        out_data_q <= pix_c;
        out_sat_q  <= sat_c;
      end
    end
  end
endmodule

// File: doc/poly_interp_mac.md
# poly_interp_mac

Parametrised polyphase interpolation MAC for the LCD scaling datapath. Each accepted input is a TAPS-wide window of unsigned pixels plus a coefficient index, and produces PHASES interpolated output pixels in one transaction. Coefficients live in a runtime-writable bank rather than fixed ROMs. Valid/ready handshakes on both sides replace the state-decoded index capture, and each output carries per-phase saturation flags.

## Interface
- DATA_WIDTH, 8, pixel width (unsigned)
- TAPS, 3, input taps per window
- PHASES, 4, output phases per window
- COEF_WIDTH, 10, signed coefficient width
- FRAC_BITS, 8, coefficient fractional bits (≥1)
- IDX_WIDTH, 7, coefficient bank address width (depth 2^IDX_WIDTH)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input window valid
- in_ready  out  1  input window accepted when in_valid & in_ready at rising clk
- in_index  in  IDX_WIDTH  coefficient set for this window
- in_data  in  TAPS*DATA_WIDTH  tap t at bits [t*DATA_WIDTH +: DATA_WIDTH]
- coef_we  in  1  coefficient write strobe
- coef_waddr  in  IDX_WIDTH  write address
- coef_wdata  in  PHASES*TAPS*COEF_WIDTH  coef(p,t) at [(p*TAPS+t)*COEF_WIDTH +: COEF_WIDTH]
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts
- out_data  out  PHASES*DATA_WIDTH  phase p at [p*DATA_WIDTH +: DATA_WIDTH]
- out_sat  out  PHASES  bit p = phase p was clamped

## Operation
- Pipeline stages:
  - S0: register in_data and a valid bit; registered synchronous read of bank[in_index].
  - S1: register PHASES*TAPS products.
  - S2: sum, round, saturate; register into out_data/out_sat/out_valid.
- Index and data are captured on the same accepting edge, so the coefficients always belong to their own window.
- Global enable en = !out_valid | out_ready. All stage registers, including the bank read register, load only when en.
- in_ready = en (combinational from out_ready). Pipeline bubbles propagate as valid=0.
- Coefficient bank:
  - Writes occur whenever coef_we is high, independent of en.
  - Read-during-write to the same address returns the old contents.
  - Contents are not reset.
- Product: signed coef × zero-extended data ({1'b0,d}), width COEF_WIDTH+DATA_WIDTH+1. Full precision, no truncation.
- Sum: TAPS products sign-extended to COEF_WIDTH+DATA_WIDTH+1+clog2(TAPS) bits.
- Rounding: add 2^(FRAC_BITS-1), then arithmetic shift right by FRAC_BITS (round half up).
- Saturation:
  - Result < 0 → 0, sat=1.
  - Result > 2^DATA_WIDTH-1 → all ones, sat=1.
  - Otherwise low DATA_WIDTH bits, sat=0.

## Timing
- Reset: out_valid=0, out_data=0, out_sat=0, all stage valids=0. in_ready=1 from reset assertion, since out_valid=0.
- Latency: a window accepted at edge k gives out_valid=1 after edge k+2. Throughput is one window per cycle with out_ready held high.
- Backpressure:
  - While out_valid & !out_ready, out_data/out_sat hold stable, no stage advances, and in_ready=0.
  - No window is lost or duplicated; output order equals acceptance order.
- Coefficient visibility:
  - A write at edge k is used by windows accepted at edge k+1 or later.
  - A window accepted at edge k with in_index==coef_waddr uses the old set.
- A bank write during a stall does not change coefficients already read into S0.
- Reset asserted mid-stream discards all in-flight windows. First output after release needs a fresh acceptance, 3 edges.
- No output handshake beyond valid/ready. out_valid drops after edge k+3 if no new data reached S2.

## Test plan
- Unity: bank[5] phase0 = (64,128,64), phases1-3 = (0,256,0); in_data = (100,100,100), index 5 → out_data all 100, out_sat=0, out_valid exactly 2 edges after accept.
- Rounding: coef(0,0)=1, others 0; tap0=128 → phase0 = 1 (128/256 = 0.5 rounds up). Tap0=127 → 0.
- Saturation: coef (-256,0,0), tap0=10 → 0, sat bit=1. Coef (511,511,511), data (255,255,255) → 255, sat=1.
- Backpressure: stream 6 windows back-to-back with out_ready low for 5 cycles mid-stream → in_ready low during the stall, all 6 outputs in order, values unchanged while stalled.
- Collision: write bank[3] (all 256 on tap1) at the same edge a window with index 3 is accepted → that window uses the old coefficients, the next window uses the new ones.
- Reset mid-stream: assert rst_n=0 with 2 windows in flight → out_valid=0, out_data=0 immediately, and no stale output appears after release.
